// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store front end that sits between the EX/MEM pipeline
// register and a word-only data memory (dm).
//   - Loads (lb/lbu/lh/lhu/lw) pick the addressed lane out of the dm word,
//     sign- or zero-extend it and register it for MEM/WB.
//   - Word stores go straight to dm in the same cycle.
//   - Byte/half stores become a read-modify-write, because dm only writes
//     whole words. The sequence is IDLE -> MERGE -> WRITE, and stall holds
//     the upstream pipeline while the new word is being built.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   When it is defined, a misaligned half or word access is blocked and
//   raises a one-cycle misalign pulse. When it is undefined, misalign is
//   tied 0, a half ignores addr[0] and a word ignores addr[1:0].
//
// Parameters
//   ADDR_W       address width; the dm word index is dm_addr[11:2]
//   BIG_ENDIAN   0: byte lane k is bits[8k+7:8k]; 1: lane order mirrored
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low
//   req_valid    in   EX/MEM holds a valid memory op
//   mem_rd       in   load
//   mem_wr       in   store (wins over mem_rd)
//   mem_size     in   00 byte, 01 half, 1x word
//   mem_unsigned in   zero-extend the load result
//   addr         in   byte address
//   wdata        in   store data, right-justified
//   dm_dout      in   dm combinational read data
//   dm_addr      out  dm address
//   dm_din       out  dm write data
//   dm_we        out  dm write enable
//   stall        out  upstream must hold EX/MEM
//   rdata        out  registered, extended load result
//   rdata_valid  out  one-cycle pulse: rdata is new
//   misalign     out  registered misalignment pulse
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       dm_dout,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misalign
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MERGE = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;
    logic [31:0]       r_mergeQ;
    logic [ADDR_W-1:0] r_addrQ;
    logic [31:0]       r_rdata;
    logic              r_rdataValid;

    logic        w_isStore;
    logic        w_isLoad;
    logic        w_isByte;
    logic        w_isHalf;
    logic        w_isWord;
    logic        w_misaligned;
    logic [1:0]  w_laneIdx;
    logic        w_halfIdx;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadData;
    logic [31:0] w_mergeWord;

    // A store wins over a load when both are requested.
    assign w_isStore = req_valid & mem_wr;
    assign w_isLoad  = req_valid & mem_rd & ~mem_wr;
    assign w_isByte  = (mem_size == 2'b00);
    assign w_isHalf  = (mem_size == 2'b01);
    assign w_isWord  = mem_size[1];

`ifdef MISALIGN_TRAP_EN
    assign w_misaligned = (w_isHalf & addr[0]) | (w_isWord & (addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // Big-endian mirrors the lane order, so lane k becomes lane 3-k.
    assign w_laneIdx = BIG_ENDIAN ? ~addr[1:0] : addr[1:0];
    assign w_halfIdx = BIG_ENDIAN ? ~addr[1]   : addr[1];

    // Extract and extend the addressed lane of the dm word for loads.
    always_comb begin
        w_byte = dm_dout[7:0];
        case (w_laneIdx)
            2'd0:    w_byte = dm_dout[7:0];
            2'd1:    w_byte = dm_dout[15:8];
            2'd2:    w_byte = dm_dout[23:16];
            default: w_byte = dm_dout[31:24];
        endcase
        w_half = w_halfIdx ? dm_dout[31:16] : dm_dout[15:0];
        if (w_isByte) begin
            w_loadData = {{24{w_byte[7] & ~mem_unsigned}}, w_byte};
        end else if (w_isHalf) begin
            w_loadData = {{16{w_half[15] & ~mem_unsigned}}, w_half};
        end else begin
            w_loadData = dm_dout;
        end
    end

    // Build the RMW word: the old dm word with the target lane(s) replaced.
    always_comb begin
        w_mergeWord = dm_dout;
        if (w_isByte) begin
            case (w_laneIdx)
                2'd0:    w_mergeWord[7:0]   = wdata[7:0];
                2'd1:    w_mergeWord[15:8]  = wdata[7:0];
                2'd2:    w_mergeWord[23:16] = wdata[7:0];
                default: w_mergeWord[31:24] = wdata[7:0];
            endcase
        end else if (w_isHalf) begin
            if (w_halfIdx) begin
                w_mergeWord[31:16] = wdata[15:0];
            end else begin
                w_mergeWord[15:0] = wdata[15:0];
            end
        end
    end

    // dm control, stall and next state. While rst is low the write enable
    // and the stall are forced low so a reset mid-RMW never leaks a write.
    always_comb begin
        w_nextState = r_state;
        dm_addr     = addr;
        dm_din      = wdata;
        dm_we       = 1'b0;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_isStore && !w_misaligned) begin
                    if (w_isWord) begin
                        dm_we = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        w_nextState = S_MERGE;
                    end
                end
            end
            S_MERGE: begin
                stall       = 1'b1;
                w_nextState = S_WRITE;
            end
            S_WRITE: begin
                // The held request is consumed here and is not re-issued.
                dm_addr     = r_addrQ;
                dm_din      = r_mergeQ;
                dm_we       = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        if (!rst) begin
            dm_we = 1'b0;
            stall = 1'b0;
        end
    end

    // State, merge buffer and the registered load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mergeQ     <= 32'd0;
            r_addrQ      <= '0;
            r_rdata      <= 32'd0;
            r_rdataValid <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_rdataValid <= 1'b0;
            if (r_state == S_IDLE && w_isLoad && !w_misaligned) begin
                r_rdata      <= w_loadData;
                r_rdataValid <= 1'b1;
            end
            if (r_state == S_MERGE) begin
                r_mergeQ <= w_mergeWord;
                r_addrQ  <= {addr[ADDR_W-1:2], 2'b00};
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;

    // One-cycle pulse for a blocked misaligned access seen in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == S_IDLE) && req_valid && (mem_rd || mem_wr) && w_misaligned;
        end
    end

    assign misalign = r_misalign;
`else
    assign misalign = 1'b0;
`endif

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdataValid;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Testbench for mem_access_unit (BIG_ENDIAN=0). A small word memory stands in
// for dm; a separate reference memory holds what every word should contain,
// updated from plain byte/half arithmetic. Directed steps cover reset, the
// word store, the byte/half RMW, sign/zero extension, reset during an RMW and
// the misaligned word load, followed by a randomized mix of operations.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        memRd;
    logic        memWr;
    logic [1:0]  memSize;
    logic        memUnsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dmDout;
    logic [31:0] dmAddr;
    logic [31:0] dmDin;
    logic        dmWe;
    logic        stall;
    logic [31:0] rdata;
    logic        rdataValid;
    logic        misalign;

    logic [31:0] dmMem  [0:1023];
    logic [31:0] refMem [0:1023];

    logic        preload = 1'b0;
    logic [9:0]  preIdx  = 10'd0;
    logic [31:0] preVal  = 32'd0;

    logic [31:0] lastRdata = 32'd0;
    int          passCount = 0;
    int          checkCount = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (reqValid),
        .mem_rd       (memRd),
        .mem_wr       (memWr),
        .mem_size     (memSize),
        .mem_unsigned (memUnsigned),
        .addr         (addr),
        .wdata        (wdata),
        .dm_dout      (dmDout),
        .dm_addr      (dmAddr),
        .dm_din       (dmDin),
        .dm_we        (dmWe),
        .stall        (stall),
        .rdata        (rdata),
        .rdata_valid  (rdataValid),
        .misalign     (misalign)
    );

    // Word-only data memory: combinational read, write on the rising edge.
    assign dmDout = dmMem[dmAddr[11:2]];

    always @(posedge clk) begin
        if (preload) begin
            dmMem[preIdx] <= preVal;
        end else if (dmWe) begin
            dmMem[dmAddr[11:2]] <= dmDin;
        end
    end

    // Expected load value from a memory word, computed with shifts and masks.
    function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [1:0] size,
                                            input logic uns, input logic [31:0] a);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (w >> (8 * a[1:0])) & 32'h0000_00FF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (w >> (16 * a[1])) & 32'h0000_FFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Expected memory word after a store of the given size.
    function automatic logic [31:0] refStore(input logic [31:0] old, input logic [1:0] size,
                                             input logic [31:0] a, input logic [31:0] wd);
        int unsigned sh;
        logic [31:0] mask;
        if (size == 2'b00) begin
            sh   = 8 * a[1:0];
            mask = 32'h0000_00FF << sh;
            return (old & ~mask) | ((wd & 32'h0000_00FF) << sh);
        end else if (size == 2'b01) begin
            sh   = 16 * a[1];
            mask = 32'h0000_FFFF << sh;
            return (old & ~mask) | ((wd & 32'h0000_FFFF) << sh);
        end
        return wd;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] a, input logic [31:0] wd);
        reqValid    = 1'b1;
        memRd       = rd;
        memWr       = wr;
        memSize     = size;
        memUnsigned = uns;
        addr        = a;
        wdata       = wd;
    endtask

    task automatic idleInputs();
        reqValid = 1'b0;
        memRd    = 1'b0;
        memWr    = 1'b0;
    endtask

    task automatic preloadWord(input int idx, input logic [31:0] val);
        preload     = 1'b1;
        preIdx      = idx[9:0];
        preVal      = val;
        refMem[idx] = val;
        @(posedge clk);
        #1;
        preload = 1'b0;
    endtask

    // One full operation, started 1 time unit after a rising edge.
    task automatic runOp(input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        int n;
        int idx;
        logic [31:0] expWord;
        idx = int'(a[11:2]);
        applyStimulus(rd, wr, size, uns, a, wd);
        #1;
        if (wr && size < 2'b10) begin
            checkOutput("rmwIdleStall", stall, 32'd1);
            checkOutput("rmwIdleWe", dmWe, 32'd0);
            n = 0;
            while (stall === 1'b1 && n < 4) begin
                @(posedge clk);
                #1;
                n++;
                if (stall === 1'b1) checkOutput("rmwMergeWe", dmWe, 32'd0);
            end
            checkOutput("rmwCycles", n, 32'd2);
            expWord = refStore(refMem[idx], size, a, wd);
            checkOutput("rmwWe", dmWe, 32'd1);
            checkOutput("rmwAddr", dmAddr, a & 32'hFFFF_FFFC);
            checkOutput("rmwDin", dmDin, expWord);
            refMem[idx] = expWord;
            @(posedge clk);
            #1;
            idleInputs();
        end else if (wr) begin
            checkOutput("swWe", dmWe, 32'd1);
            checkOutput("swAddr", dmAddr, a);
            checkOutput("swDin", dmDin, wd);
            checkOutput("swStall", stall, 32'd0);
            refMem[idx] = wd;
            @(posedge clk);
            #1;
            idleInputs();
        end else begin
            checkOutput("ldStall", stall, 32'd0);
            checkOutput("ldWe", dmWe, 32'd0);
            expWord = refLoad(refMem[idx], size, uns, a);
            @(posedge clk);
            #1;
            checkOutput("ldValid", rdataValid, 32'd1);
            checkOutput("ldData", rdata, expWord);
            checkOutput("ldMisalign", misalign, 32'd0);
            lastRdata = expWord;
            idleInputs();
        end
        if (wr) checkOutput("memWord", dmMem[idx], refMem[idx]);
    endtask

    // One cycle where the unit must do nothing and hold rdata.
    task automatic quietCycle(input logic validNoOp);
        reqValid = validNoOp;
        memRd    = 1'b0;
        memWr    = 1'b0;
        #1;
        checkOutput("quietWe", dmWe, 32'd0);
        checkOutput("quietStall", stall, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("quietValid", rdataValid, 32'd0);
        checkOutput("quietHold", rdata, lastRdata);
        idleInputs();
    endtask

    initial begin
        int kind;
        int idx;
        logic [31:0] a;
        logic [31:0] wd;

        rst = 1'b0;
        idleInputs();
        memSize     = 2'b10;
        memUnsigned = 1'b0;
        addr        = 32'd0;
        wdata       = 32'd0;

        // Fill the low 16 words while reset is held.
        for (int i = 0; i < 16; i++) preloadWord(i, $urandom);
        checkOutput("resetStall", stall, 32'd0);
        checkOutput("resetWe", dmWe, 32'd0);
        checkOutput("resetRdata", rdata, 32'd0);
        checkOutput("resetValid", rdataValid, 32'd0);
        checkOutput("resetMisalign", misalign, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] word store");
        runOp(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);

        $display("[TB] byte and half read-modify-write");
        preloadWord(4, 32'h1122_3344);
        runOp(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB);
        checkOutput("sbWord", dmMem[4], 32'h1122_AB44);
        preloadWord(4, 32'h1122_3344);
        runOp(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF);
        checkOutput("shWord", dmMem[4], 32'hBEEF_3344);

        $display("[TB] load extension");
        preloadWord(4, 32'h80FF_FFFF);
        runOp(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
        checkOutput("lbValue", rdata, 32'hFFFF_FF80);
        runOp(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
        checkOutput("lbuValue", rdata, 32'h0000_0080);
        runOp(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
        checkOutput("lhValue", rdata, 32'hFFFF_80FF);
        runOp(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'd0);
        checkOutput("lhuValue", rdata, 32'h0000_80FF);

        $display("[TB] reset mid-run");
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midResetStall", stall, 32'd0);
        checkOutput("midResetWe", dmWe, 32'd0);
        checkOutput("midResetRdata", rdata, 32'd0);
        checkOutput("midResetValid", rdataValid, 32'd0);
        lastRdata = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] misaligned word load");
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'd0);
        #1;
        checkOutput("lwMisWe", dmWe, 32'd0);
        @(posedge clk);
        #1;
`ifdef MISALIGN_TRAP_EN
        checkOutput("lwMisFlag", misalign, 32'd1);
        checkOutput("lwMisValid", rdataValid, 32'd0);
        idleInputs();
        @(posedge clk);
        #1;
        checkOutput("lwMisPulse", misalign, 32'd0);
`else
        checkOutput("lwMisFlag", misalign, 32'd0);
        checkOutput("lwMisValid", rdataValid, 32'd1);
        checkOutput("lwMisData", rdata, refMem[4]);
        lastRdata = refMem[4];
        idleInputs();
`endif

        $display("[TB] reset during merge");
        preloadWord(5, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_0055);
        #1;
        @(posedge clk);
        #1;
        checkOutput("mergeStall", stall, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("mergeRstStall", stall, 32'd0);
        checkOutput("mergeRstWe", dmWe, 32'd0);
        idleInputs();
        @(posedge clk);
        #1;
        checkOutput("mergeRstWe2", dmWe, 32'd0);
        rst = 1'b1;
        lastRdata = 32'd0;
        #1;
        checkOutput("mergeRelStall", stall, 32'd0);
        checkOutput("mergeRelWe", dmWe, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mergeIdleStall", stall, 32'd0);
        checkOutput("mergeIdleWe", dmWe, 32'd0);
        checkOutput("mergeMemKept", dmMem[5], 32'hCAFE_F00D);

        $display("[TB] randomized operations");
        for (int it = 0; it < 120; it++) begin
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 15);
            wd   = $urandom;
            case (kind)
                0, 1: begin
                    a = idx * 4 + $urandom_range(0, 3);
                    runOp(1'b1, 1'b0, 2'b00, kind[0], a, wd);
                end
                2, 3: begin
                    a = idx * 4 + 2 * $urandom_range(0, 1);
                    runOp(1'b1, 1'b0, 2'b01, kind[0], a, wd);
                end
                4: runOp(1'b1, 1'b0, 2'b10, 1'b0, idx * 4, wd);
                5: begin
                    a = idx * 4 + $urandom_range(0, 3);
                    runOp(1'b0, 1'b1, 2'b00, 1'b0, a, wd);
                end
                6: begin
                    a = idx * 4 + 2 * $urandom_range(0, 1);
                    runOp($urandom_range(0, 1) == 1, 1'b1, 2'b01, 1'b0, a, wd);
                end
                7: runOp(1'b0, 1'b1, 2'b11, 1'b0, idx * 4, wd);
                8: quietCycle(1'b0);
                default: quietCycle(1'b1);
            endcase
        end

        for (int i = 0; i < 16; i++) checkOutput("finalMem", dmMem[i], refMem[i]);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
